// File: rtl/sensor_array_controller.sv
// Multi-channel windowed rising-edge counter with a done/ack handshake, overrun and saturation flags.
// Define SENSOR_CTRL_SYNC_EN to put a two-flop synchronizer in front of each channel's edge detector.
module sensor_array_controller #(
  parameter int unsigned SENSORS  = 1,
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned WINDOW   = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SENSORS-1:0]           sensors,
  output logic [SENSORS*BITWIDTH-1:0]  data,
  output logic [SENSORS-1:0]           saturated,
  output logic                         sensor_done,
  output logic                         overrun,
  input  logic                         ack
);

  localparam int unsigned         WinW    = $clog2(WINDOW);
  localparam logic [WinW-1:0]     WinLast = WinW'(WINDOW - 1);
  localparam logic [BITWIDTH-1:0] CntMax  = '1;

  typedef enum logic {StIdle, StReady} state_e;

  logic [SENSORS-1:0] edge_det;

`ifdef SENSOR_CTRL_SYNC_EN
  logic [SENSORS-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= sensors;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_det = s2_q & ~s3_q;
`else
  logic [SENSORS-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sensors;
      s2_q <= s1_q;
    end
  end

  assign edge_det = s1_q & ~s2_q;
`endif

  logic [WinW-1:0]                    win_q, win_d;
  logic [SENSORS-1:0][BITWIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SENSORS-1:0][BITWIDTH-1:0]   data_q, data_d;
  logic [SENSORS-1:0]                 sat_q, sat_d, sat_upd;
  logic [SENSORS-1:0]                 saturated_q, saturated_d;
  logic                               overrun_q, overrun_d;
  state_e                             state_q, state_d;
  logic                               terminal;

  assign terminal = (win_q == WinLast);

  // Counters and sat bits see this cycle's edge before the terminal snapshot, so nothing is lost.
  always_comb begin
    cnt_inc = cnt_q;
    sat_upd = sat_q;
    for (int unsigned i = 0; i < SENSORS; i++) begin
      if (edge_det[i] && (cnt_q[i] != CntMax)) begin
        cnt_inc[i] = cnt_q[i] + 1'b1;
      end
      sat_upd[i] = sat_q[i] | (cnt_inc[i] == CntMax);
    end
  end

  always_comb begin
    win_d       = terminal ? '0 : win_q + 1'b1;
    cnt_d       = terminal ? '0 : cnt_inc;
    sat_d       = terminal ? '0 : sat_upd;
    data_d      = terminal ? cnt_inc : data_q;
    saturated_d = terminal ? sat_upd : saturated_q;
  end

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (terminal) state_d = StReady;
      end
      StReady: begin
        // An ack consumes the old data even if a new window lands on the same edge.
        if (ack) begin
          overrun_d = 1'b0;
        end else if (terminal) begin
          overrun_d = 1'b1;
        end
        if (ack && !terminal) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= '0;
      data_q      <= '0;
      saturated_q <= '0;
      overrun_q   <= 1'b0;
      state_q     <= StIdle;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      data_q      <= data_d;
      saturated_q <= saturated_d;
      overrun_q   <= overrun_d;
      state_q     <= state_d;
    end
  end

  assign data        = data_q;
  assign saturated   = saturated_q;
  assign sensor_done = (state_q == StReady);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sensor_array_controller.sv
// Directed-plus-random bench for sensor_array_controller: a 4-bit and a 3-bit instance share stimulus
// and are checked every cycle against a window-count reference model.
module tb_sensor_array_controller;

  localparam int WIN = 16;
`ifdef SENSOR_CTRL_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic       clk, rst, ack;
  logic [1:0] sensors;
  logic [7:0] data4;
  logic [5:0] data3;
  logic [1:0] sat4, sat3;
  logic       done4, done3, over4, over3;

  sensor_array_controller #(.SENSORS(2), .BITWIDTH(4), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .sensors(sensors), .data(data4), .saturated(sat4),
    .sensor_done(done4), .overrun(over4), .ack(ack)
  );

  sensor_array_controller #(.SENSORS(2), .BITWIDTH(3), .WINDOW(WIN)) dut3 (
    .clk(clk), .rst(rst), .sensors(sensors), .data(data3), .saturated(sat3),
    .sensor_done(done3), .overrun(over3), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: history of sampled sensor values since reset release.
  logic [1:0] hist [0:511];
  int         n;
  logic       exp_done, exp_over;
  int         exp_d4 [2];
  int         exp_d3 [2];
  logic [1:0] exp_s4, exp_s3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Rising edges of a channel that reach the counter on posedges n_end-WIN+1 .. n_end.
  function automatic int win_count(int n_end, int ch);
    int c = 0;
    for (int k = n_end - WIN + 1; k <= n_end; k++) begin
      int i = k - Lat;
      if (i >= 1 && hist[i][ch] && !hist[i-1][ch]) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    n = 0;
    hist[0] = 2'b00;
    exp_done = 1'b0;
    exp_over = 1'b0;
    exp_s4 = '0;
    exp_s3 = '0;
    for (int ch = 0; ch < 2; ch++) begin
      exp_d4[ch] = 0;
      exp_d3[ch] = 0;
    end
  endtask

  task automatic model_tick(input logic [1:0] s, input logic a);
    n++;
    hist[n] = s;
    if (n % WIN == 0) begin
      for (int ch = 0; ch < 2; ch++) begin
        int c = win_count(n, ch);
        exp_d4[ch] = (c > 15) ? 15 : c;
        exp_s4[ch] = (c >= 15);
        exp_d3[ch] = (c > 7) ? 7 : c;
        exp_s3[ch] = (c >= 7);
      end
      if (exp_done) exp_over = !a;
      exp_done = 1'b1;
    end else if (a && exp_done) begin
      exp_done = 1'b0;
      exp_over = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("done",    32'(done4),      32'(exp_done));
    chk("overrun", 32'(over4),      32'(exp_over));
    chk("d4_ch0",  32'(data4[3:0]), 32'(exp_d4[0]));
    chk("d4_ch1",  32'(data4[7:4]), 32'(exp_d4[1]));
    chk("sat4",    32'(sat4),       32'(exp_s4));
    chk("done3",   32'(done3),      32'(exp_done));
    chk("over3",   32'(over3),      32'(exp_over));
    chk("d3_ch0",  32'(data3[2:0]), 32'(exp_d3[0]));
    chk("d3_ch1",  32'(data3[5:3]), 32'(exp_d3[1]));
    chk("sat3",    32'(sat3),       32'(exp_s3));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data4"}, 32'(data4), 0);
    chk({tag, "_sat4"},  32'(sat4),  0);
    chk({tag, "_done4"}, 32'(done4), 0);
    chk({tag, "_over4"}, 32'(over4), 0);
    chk({tag, "_data3"}, 32'(data3), 0);
    chk({tag, "_done3"}, 32'(done3), 0);
  endtask

  task automatic step(input logic [1:0] s, input logic a);
    sensors = s;
    ack = a;
    @(posedge clk);
    model_tick(s, a);
    #1;
    check_all();
  endtask

  task automatic run(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] ak,
                     input int lo, input int hi);
    for (int k = lo; k <= hi; k++) step({p1[k], p0[k]}, ak[k]);
  endtask

  logic [15:0] bp;

  initial begin
    rst = 1'b0;
    sensors = 2'b00;
    ack = 1'b0;
    model_reset();

    // Reset values with random inputs, then release.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sensors = 2'($urandom);
      ack = 1'($urandom);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    rst = 1'b1;

    // Window 1: five pulses on ch0; done must appear exactly on the 16th edge.
    run(16'h0155, 16'h0000, 16'h0000, 0, 14);
    chk("pre_done", 32'(done4), 0);
    step(2'b00, 1'b0);
    chk("first_done", 32'(done4), 1);
    chk("basic_ch0", 32'(data4[3:0]), 5);
    chk("basic_ch1", 32'(data4[7:4]), 0);
    chk("basic_sat", 32'(sat4), 0);

    // Ack clears done next cycle; ch1 toggles continuously for two windows.
    step(2'b10, 1'b1);
    chk("ack_clears", 32'(done4), 0);
    run(16'h0000, 16'h5555, 16'h0000, 1, 15);
    run(16'h0000, 16'h5555, 16'h0001, 0, 15);
    chk("sat_ch1_b4",   32'(data4[7:4]), 8);
    chk("sat_flag_b4",  32'(sat4[1]),    0);
    chk("sat_ch1_b3",   32'(data3[5:3]), 7);
    chk("sat_flag_b3",  32'(sat3[1]),    1);

    // Overrun: two terminal cycles without ack.
    run(16'h0150, 16'h0000, 16'h0001, 0, 15);
    run(16'h0050, 16'h0000, 16'h0000, 0, 15);
    chk("ovr_flag", 32'(over4), 1);
    chk("ovr_done", 32'(done4), 1);
    chk("ovr_ch0",  32'(data4[3:0]), 2);
    step(2'b00, 1'b1);
    chk("ovr_clr_done", 32'(done4), 0);
    chk("ovr_clr_flag", 32'(over4), 0);
    run(16'h0000, 16'h0000, 16'h0000, 1, 15);

    // Set overrun again, then ack exactly on the terminal cycle.
    run(16'h0004, 16'h0000, 16'h0000, 0, 15);
    chk("pre_sim_over", 32'(over4), 1);
    run(16'h0550, 16'h0000, 16'h8000, 0, 15);
    chk("sim_done", 32'(done4), 1);
    chk("sim_over", 32'(over4), 0);
    chk("sim_ch0",  32'(data4[3:0]), 4);

    // Single edge that reaches the detector on the terminal cycle.
    bp = 16'hFFFF << (15 - Lat);
    run(bp, 16'h0000, 16'h0001, 0, 15);
    chk("bnd_ch0", 32'(data4[3:0]), 1);

    // Random activity, then reset asserted mid-window.
    run(16'($urandom), 16'($urandom), 16'h0001, 0, 6);
    #1;
    rst = 1'b0;
    #1;
    check_zero("midrst");
    sensors = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    run(16'h0054, 16'h0000, 16'h0000, 0, 14);
    chk("rst_pre_done", 32'(done4), 0);
    step(2'b00, 1'b0);
    chk("rst_done", 32'(done4), 1);
    chk("rst_ch0",  32'(data4[3:0]), 3);
    chk("rst_ch1",  32'(data4[7:4]), 0);

    // Random windows with sparse random acks.
    repeat (6) begin
      run(16'($urandom), 16'($urandom), 16'($urandom & $urandom & $urandom), 0, 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_array_controller.md
# sensor_array_controller

Multi-channel successor to the single-channel sensor controller. It counts rising edges on `SENSORS` independent sensor lines over a fixed sampling window of `WINDOW` clock cycles. At the end of each window it latches every channel's count into a parallel output buffer and raises `sensor_done`. It then holds the `sensor_done`/`ack` handshake with the downstream consumer, and flags overruns and per-channel saturation.

## Interface
- `SENSORS`, 1: number of sensor channels (≥1).
- `BITWIDTH`, 32: per-channel count width (≥2).
- `WINDOW`, 1000: sampling window length in clock cycles (≥2). The window counter width is `$clog2(WINDOW)`.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `sensors`  input  SENSORS  raw sensor lines, bit i = channel i; asynchronous to `clk`.
- `data`  output  SENSORS*BITWIDTH  latched counts; channel i at `[i*BITWIDTH +: BITWIDTH]`.
- `saturated`  output  SENSORS  bit i = channel i's latched count hit all-ones.
- `sensor_done`  output  1  latched data valid, awaiting `ack`.
- `overrun`  output  1  a window completed while `sensor_done` was still high.
- `ack`  input  1  consumer acknowledge, sampled on `clk`.

## Operation
- **Reset** (`rst` = 0): the following clear to 0, asynchronously: `data`, `saturated`, `sensor_done`, `overrun`, all channel counters, the window counter, and all input sampling registers.
- **Edge detect:** per channel, `edge = cur & ~prev` on the sampled input. After reset `prev` = 0, so a line already high at reset release counts as one edge.
- **Counting:**
  - Each channel counter increments on its edge.
  - A counter saturates at 2^BITWIDTH−1 and never wraps.
  - A per-channel sticky sat bit sets when the counter is at max and another edge arrives, or when the count reaches max.
- **Window counter:** runs 0..WINDOW−1 continuously and wraps to 0. Counting never pauses; no edges are lost across windows or while awaiting `ack`.
- **Terminal cycle** (window counter = WINDOW−1):
  - `data` takes counter + edge for each channel, saturated, so an edge on the terminal cycle is included.
  - `saturated` takes the sat bits.
  - Counters and sat bits restart at 0.
  - `sensor_done` is set to 1.
- **Handshake:**
  - `ack` = 1 while `sensor_done` = 1 clears `sensor_done` and `overrun` on the next edge.
  - `ack` while `sensor_done` = 0 is ignored.
- **Overrun:**
  - A terminal cycle with `sensor_done` = 1 and `ack` = 0 overwrites `data`/`saturated` with the newest window and sets `overrun` (sticky).
  - `sensor_done` stays 1.
- **Simultaneous terminal cycle and `ack`:**
  - The new data is latched and `sensor_done` stays 1.
  - `overrun` is cleared, not set, because the old data was consumed.
- **State machine**, 2 states:
  - IDLE (`sensor_done` = 0) → READY on a terminal cycle.
  - READY → IDLE on `ack` without a terminal cycle.
  - READY → READY on a terminal cycle, with or without `ack`.

## Timing
- Terminal cycle at edge N: `data`, `saturated` and `sensor_done` are valid after edge N.
- First `sensor_done` arrives WINDOW cycles after reset release.
- Input-to-count latency:
  - 3 cycles with the synchronizer compiled in.
  - 2 cycles without it.
- Edges within the final 2 (or 1) cycles of a window land in the next window.
- `ack` → `sensor_done` low: 1 cycle.
- Reset asserted mid-window or mid-handshake aborts immediately. The next window starts fresh from 0 after release.
- Minimum sensor high/low pulse for a guaranteed count: 1 clock cycle each, after sampling.

## Configuration
- `SENSOR_CTRL_SYNC_EN` defined:
  - Each channel passes through a two-flop synchronizer before the edge-detect register.
  - `edge = s2 & ~s3`.
  - Input-to-count latency is 3 cycles.
- Undefined:
  - A single sampling register feeds edge detect.
  - `edge = s1 & ~s2`.
  - Input-to-count latency is 2 cycles.
  - For use only when `sensors` is already synchronous to `clk`.

## Test plan
All scenarios use `SENSORS` = 2, `BITWIDTH` = 4, `WINDOW` = 16, sync enabled.
- **Reset values:** hold `rst` = 0 with random `sensors`/`ack` → all outputs 0. Release → `sensor_done` rises exactly 16 cycles later.
- **Basic count:** 5 single-cycle-spaced pulses on ch0, ch1 low, all early in the window → `data` = {ch1=0, ch0=5}, `saturated` = 00, `sensor_done` = 1. `ack` → `sensor_done` = 0 next cycle.
- **Saturation:** 20 pulses on ch1 across windows is impossible in 16 cycles, so use 8 toggles per window over one window for ch1 = 8, then set `BITWIDTH` = 3 → ch1 `data` = 7, `saturated[1]` = 1, no wrap to 0.
- **Overrun:** no `ack` across two terminal cycles, with 3 pulses in window 1 and 2 in window 2 → `data` ch0 = 2, `overrun` = 1, `sensor_done` = 1. `ack` clears both next cycle.
- **Simultaneous:** `ack` = 1 exactly on the terminal cycle while `sensor_done` = 1 → new data latched, `sensor_done` stays 1, `overrun` = 0.
- **Boundary edge and mid-operation reset:**
  - A sensor edge reaching edge detect on the terminal cycle is counted in that window.
  - Asserting `rst` mid-window clears counts; the window after release reports only post-reset edges.
